// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty controller: state encodings,
// duty width and default parameter values.
package pwm_pkg;

  localparam int DUTY_W               = 5;
  localparam int DIV_DEFAULT          = 20;
  localparam int DEBOUNCE_DEFAULT     = 4;
  localparam int STEP_PERIODS_DEFAULT = 4;

  typedef logic [DUTY_W-1:0] duty_t;

  // Plain 2-bit encodings so the state port carries legacy-compatible codes.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_MANUAL  = 2'd0;
  localparam fsm_state_t ST_BR_UP   = 2'd1;
  localparam fsm_state_t ST_BR_DOWN = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF synchronizer, consecutive-sample debounce
// filter and a registered one-cycle pulse on each accepted 0->1 change.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic       level_d;
  logic [3:0] stable_cnt;

  // Two-stage synchronizer for the asynchronous button input.
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      level      <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 4'd1;
    end
  end

  // Registered rising-edge detect on the debounced level.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM generator with button-controlled duty (manual mode) and an automatic
// triangular duty ramp (breathe mode). Duty changes are staged in a shadow
// register and applied only at the end of a period.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int DIV          = DIV_DEFAULT,
  parameter int DEBOUNCE     = DEBOUNCE_DEFAULT,
  parameter int STEP_PERIODS = STEP_PERIODS_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       mode_btn,
  output logic       pwm_out,
  output logic [4:0] duty,
  output logic [1:0] state,
  output logic       period_end
);

  localparam duty_t      DUTY_MAX   = duty_t'(DIV);
  localparam duty_t      DUTY_RESET = duty_t'(DIV / 2);
  localparam duty_t      CNT_LAST   = duty_t'(DIV - 1);
  localparam logic [3:0] STEP_LAST  = 4'(STEP_PERIODS - 1);

  duty_t      period_cnt;
  duty_t      duty_sh;
  duty_t      duty_active;
  duty_t      duty_nxt;
  fsm_state_t state_nxt;
  logic [3:0] step_cnt;
  logic [3:0] step_nxt;
  logic       inc_p;
  logic       dec_p;
  logic       mode_p;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc_db (
    .clk_in (clk_in),
    .rst    (rst),
    .raw    (inc),
    .press  (inc_p)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dec_db (
    .clk_in (clk_in),
    .rst    (rst),
    .raw    (dec),
    .press  (dec_p)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_db (
    .clk_in (clk_in),
    .rst    (rst),
    .raw    (mode_btn),
    .press  (mode_p)
  );

  assign period_end = (period_cnt == CNT_LAST);
  assign duty       = duty_active;

  // Free-running period counter, 0..DIV-1.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_end) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 5'd1;
    end
  end

  // Registered compare output and end-of-period load of the active duty.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      duty_active <= DUTY_RESET;
    end else begin
      pwm_out <= (period_cnt < duty_active);
      if (period_end) begin
        duty_active <= duty_sh;
      end
    end
  end

  // Next-state logic for the mode FSM, shadow duty and breathe step counter.
  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_sh;
    step_nxt  = step_cnt;
    case (state)
      ST_MANUAL: begin
        step_nxt = '0;
        if (mode_p) begin
          state_nxt = ST_BR_UP;
        end else if (inc_p && !dec_p) begin
          if (duty_sh < DUTY_MAX) duty_nxt = duty_sh + 5'd1;
        end else if (dec_p && !inc_p) begin
          if (duty_sh != '0) duty_nxt = duty_sh - 5'd1;
        end
      end
      ST_BR_UP: begin
        if (mode_p) begin
          state_nxt = ST_MANUAL;
        end else if (period_end) begin
          if (step_cnt != STEP_LAST) begin
            step_nxt = step_cnt + 4'd1;
          end else begin
            step_nxt = '0;
            if (duty_sh >= DUTY_MAX) begin
              // Already at the top: turn around without stepping.
              state_nxt = ST_BR_DOWN;
            end else begin
              duty_nxt = duty_sh + 5'd1;
              if (duty_sh == DUTY_MAX - 5'd1) state_nxt = ST_BR_DOWN;
            end
          end
        end
      end
      ST_BR_DOWN: begin
        if (mode_p) begin
          state_nxt = ST_MANUAL;
        end else if (period_end) begin
          if (step_cnt != STEP_LAST) begin
            step_nxt = step_cnt + 4'd1;
          end else begin
            step_nxt = '0;
            if (duty_sh == '0) begin
              state_nxt = ST_BR_UP;
            end else begin
              duty_nxt = duty_sh - 5'd1;
              if (duty_sh == 5'd1) state_nxt = ST_BR_UP;
            end
          end
        end
      end
      default: begin
        state_nxt = ST_MANUAL;
      end
    endcase
    // A fresh state always starts its step count from zero.
    if (state_nxt != state) step_nxt = '0;
  end

  // Control registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= ST_MANUAL;
      duty_sh  <= DUTY_RESET;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      duty_sh  <= duty_nxt;
      step_cnt <= step_nxt;
    end
  end

endmodule
